combi_mode_switch_ctrl: RTL

//  Sequences an ISA mode change (RISC-V <-> ARM) in the combined pipeline.
//  On a switch request from Execute: freezes fetch, bubbles younger stages, lets older M/W retire,

---
 rtl/combi_mode_switch_ctrl_if.sv | 28 ++
 rtl/combi_mode_switch_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/combi_mode_switch_ctrl_if.sv
// Handshake and pipeline-control bundle between Execute/hazard logic and the ISA mode-switch sequencer.
`timescale 1ns/1ps
interface combi_mode_switch_ctrl_if #(
   parameter int unsigned PC_W = 32
);
   logic            switch_req;
   logic            switch_to_arm;
   logic [PC_W-1:0] switch_pc;
   logic            mem_stall;
   logic            arm;
   logic            busy;
   logic            StallF;
   logic            FlushD;
   logic            FlushE;
   logic            pc_redirect_en;
   logic [PC_W-1:0] pc_redirect;
   logic            switch_ack;

   modport slave (
      input  switch_req, switch_to_arm, switch_pc, mem_stall,
      output arm, busy, StallF, FlushD, FlushE, pc_redirect_en, pc_redirect, switch_ack
   );

   modport master (
      output switch_req, switch_to_arm, switch_pc, mem_stall,
      input  arm, busy, StallF, FlushD, FlushE, pc_redirect_en, pc_redirect, switch_ack
   );
endinterface

// File: rtl/combi_mode_switch_ctrl.sv
// Sequences a RISC-V <-> ARM mode change: freeze fetch, drain M/W, flip 'arm', redirect fetch.
`timescale 1ns/1ps
module combi_mode_switch_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter logic        RESET_ARM    = 1'b0,
   parameter int unsigned PC_W         = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   combi_mode_switch_ctrl_if.slave bus
);

   // A zero-cycle drain never enters DRAIN, so the counter just needs a legal width.
   localparam int unsigned     CNT_W    = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAIN  = 2'd1,
      S_SWITCH = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tgt_arm_q, tgt_arm_d;
   logic [PC_W-1:0]   tgt_pc_q, tgt_pc_d;
   logic              arm_q, arm_d;

   logic              busy, stall_f, flush_d, flush_e, redirect_en, ack;
   logic [PC_W-1:0]   redirect_pc;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tgt_arm_q <= RESET_ARM;
         tgt_pc_q  <= '0;
         arm_q     <= RESET_ARM;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tgt_arm_q <= tgt_arm_d;
         tgt_pc_q  <= tgt_pc_d;
         arm_q     <= arm_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tgt_arm_d   = tgt_arm_q;
      tgt_pc_d    = tgt_pc_q;
      arm_d       = arm_q;
      busy        = 1'b0;
      stall_f     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = '0;
      ack         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.switch_req) begin
               tgt_arm_d = bus.switch_to_arm;
               tgt_pc_d  = bus.switch_pc;
               cnt_d     = CNT_LOAD;
               // A same-mode request has nothing older to protect, so it skips the drain.
               if ((bus.switch_to_arm != arm_q) && (DRAIN_CYCLES != 0)) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_SWITCH;
               end
            end
         end

         S_DRAIN: begin
            busy    = 1'b1;
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (!bus.mem_stall) begin
               if (cnt_q == '0) begin
                  state_d = S_SWITCH;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end

         S_SWITCH: begin
            busy        = 1'b1;
            flush_d     = 1'b1;
            redirect_en = 1'b1;
            redirect_pc = tgt_pc_q;
            ack         = 1'b1;
            arm_d       = tgt_arm_q;
            state_d     = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.arm            = arm_q;
   assign bus.busy           = busy;
   assign bus.StallF         = stall_f;
   assign bus.FlushD         = flush_d;
   assign bus.FlushE         = flush_e;
   assign bus.pc_redirect_en = redirect_en;
   assign bus.pc_redirect    = redirect_pc;
   assign bus.switch_ack     = ack;

endmodule
